// File: rtl/riscv_pkg.sv
// Shared opcodes, control enums and the Moore control bundle for the
// multi-cycle RV32I control path.
package riscv_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } srca_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } srcb_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } ctrl_state_e;

    // Pure state-derived controls; fetch/branch/retire_on_ready are
    // qualified with mem_ready/zero in the top level.
    typedef struct packed {
        logic    mem_req;
        logic    mem_write;
        logic    adr_src;
        logic    fetch;
        logic    pc_update;
        logic    branch;
        logic    reg_write;
        logic    retire;
        logic    retire_on_ready;
        srca_e   alu_src_a;
        srcb_e   alu_src_b;
        alu_op_e alu_op;
        result_e result_src;
    } ctrl_out_t;

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// Combinational map from control state to the Moore control bundle.
module mc_ctrl_out_decode
    import riscv_pkg::*;
(
    input  ctrl_state_e state,
    output ctrl_out_t   co
);

    // State -> datapath controls; everything not mentioned stays 0.
    always_comb begin
        co = '0;
        case (state)
            S_FETCH: begin
                co.mem_req    = 1'b1;
                co.fetch      = 1'b1;
                co.alu_src_a  = SRCA_PC;
                co.alu_src_b  = SRCB_FOUR;
                co.alu_op     = ALU_ADD;
                co.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                co.alu_src_a = SRCA_OLDPC;
                co.alu_src_b = SRCB_IMM;
                co.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                co.alu_src_a = SRCA_RS1;
                co.alu_src_b = SRCB_IMM;
                co.alu_op    = ALU_ADD;
            end
            S_MEMREAD: begin
                co.mem_req = 1'b1;
                co.adr_src = 1'b1;
            end
            S_MEMWB: begin
                co.result_src = RES_MEMDATA;
                co.reg_write  = 1'b1;
                co.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                co.mem_req         = 1'b1;
                co.mem_write       = 1'b1;
                co.adr_src         = 1'b1;
                co.retire_on_ready = 1'b1;
            end
            S_EXECR: begin
                co.alu_src_a = SRCA_RS1;
                co.alu_src_b = SRCB_RS2;
                co.alu_op    = ALU_FUNCT;
            end
            S_EXECI: begin
                co.alu_src_a = SRCA_RS1;
                co.alu_src_b = SRCB_IMM;
                co.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                co.result_src = RES_ALUOUT;
                co.reg_write  = 1'b1;
                co.retire     = 1'b1;
            end
            S_BEQ: begin
                co.alu_src_a  = SRCA_RS1;
                co.alu_src_b  = SRCB_RS2;
                co.alu_op     = ALU_SUB;
                co.result_src = RES_ALUOUT;
                co.branch     = 1'b1;
                co.retire     = 1'b1;
            end
            S_JAL: begin
                co.alu_src_a  = SRCA_OLDPC;
                co.alu_src_b  = SRCB_FOUR;
                co.alu_op     = ALU_ADD;
                co.result_src = RES_ALUOUT;
                co.pc_update  = 1'b1;
            end
            default: co = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences ALU, memory
// port and register file, stalls on mem_ready, counts retirements.
module multicycle_control_fsm
    import riscv_pkg::*;
#(
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_write,
    output logic                    adr_src,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    reg_write,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [1:0]              result_src,
    output logic                    instr_retired,
    output logic                    illegal_instr,
    output logic [RETIRE_CNT_W-1:0] instret,
    output logic [3:0]              state_dbg
);

    ctrl_state_e             state;
    ctrl_state_e             state_next;
    ctrl_out_t               co;
    logic                    retire;
    logic                    pcw;
    logic                    irw;
    logic                    illegal_q;
    logic [RETIRE_CNT_W-1:0] instret_q;

    mc_ctrl_out_decode u_decode (
        .state (state),
        .co    (co)
    );

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    // Next-state logic: memory states wait for mem_ready, TRAP absorbs.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_EXECR;
                    OP_I:         state_next = S_EXECI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BEQ:      state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_FETCH;
        endcase
    end

    // Handshake/flag qualified strobes.
    always_comb begin
        irw    = co.fetch & mem_ready;
        pcw    = co.pc_update | irw | (co.branch & zero);
        retire = co.retire | (co.retire_on_ready & mem_ready);
    end

    // Retired-instruction counter, wraps modulo 2^RETIRE_CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      instret_q <= '0;
        else if (retire) instret_q <= instret_q + 1'b1;
    end

    // Sticky illegal-instruction flag, set on entry to TRAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   illegal_q <= 1'b0;
        else if (state_next == S_TRAP) illegal_q <= 1'b1;
    end

    // Outputs forced low while reset is held; state_dbg shows FETCH then.
    always_comb begin
        mem_req       = reset & co.mem_req;
        mem_write     = reset & co.mem_write;
        adr_src       = reset & co.adr_src;
        ir_write      = reset & irw;
        pc_write      = reset & pcw;
        reg_write     = reset & co.reg_write;
        alu_src_a     = reset ? co.alu_src_a  : '0;
        alu_src_b     = reset ? co.alu_src_b  : '0;
        alu_op        = reset ? co.alu_op     : '0;
        result_src    = reset ? co.result_src : '0;
        instr_retired = reset & retire;
        illegal_instr = reset & illegal_q;
        instret       = reset ? instret_q : '0;
        state_dbg     = state;
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: stimulus pushes per-instruction expectations derived
// from opcode latency rules and chosen memory wait counts; a monitor pops
// and compares whenever instr_retired pulses.
module tb_multicycle_control_fsm;

    localparam int unsigned W = 4;
    localparam logic [6:0] T_LW   = 7'b0000011;
    localparam logic [6:0] T_SW   = 7'b0100011;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_BEQ  = 7'b1100011;
    localparam logic [6:0] T_JAL  = 7'b1101111;
    localparam logic [6:0] T_ECALL = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    opcode;
    logic          zero;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
    logic          instr_retired, illegal_instr;
    logic [W-1:0]  instret;
    logic [3:0]    state_dbg;

    multicycle_control_fsm #(.RETIRE_CNT_W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .result_src    (result_src),
        .instr_retired (instr_retired),
        .illegal_instr (illegal_instr),
        .instret       (instret),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic       z;
    } instr_t;

    typedef struct {
        logic [6:0]  op;
        logic        z;
        int unsigned lat;
        int unsigned pcw;
        int unsigned regw;
        logic        funct;
    } exp_t;

    instr_t      prog[$];
    int unsigned waits[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int unsigned total_issued = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Instruction register model: next program word latched on ir_write.
    logic [6:0] ir = 7'd0;
    logic       ir_z = 1'b0;
    assign opcode = ir;
    assign zero   = ir_z;

    always @(posedge clk) begin
        if (reset && ir_write && prog.size() > 0) begin
            instr_t t;
            t = prog.pop_front();
            ir   <= t.op;
            ir_z <= t.z;
        end
    end

    // Memory model: each access takes its queued number of wait cycles;
    // fetches stall while the program queue is empty.
    logic        busy = 1'b0;
    logic        idle_stall = 1'b0;
    int unsigned cur_wait = 0;

    always @(negedge clk) begin
        if (!reset) begin
            mem_ready  = 1'b0;
            busy       = 1'b0;
            idle_stall = 1'b0;
        end else begin
            if (mem_ready) busy = 1'b0;
            idle_stall = 1'b0;
            if (!mem_req) begin
                mem_ready = 1'b0;
            end else if (!busy && !adr_src && prog.size() == 0) begin
                mem_ready  = 1'b0;
                idle_stall = 1'b1;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    cur_wait = 0;
                    if (waits.size() > 0) cur_wait = waits.pop_front();
                end
                if (cur_wait == 0) mem_ready = 1'b1;
                else begin
                    mem_ready = 1'b0;
                    cur_wait--;
                end
            end
        end
    end

    // Monitor: accumulates per-instruction activity, checks on retire.
    int unsigned cyc = 0, pcw_n = 0, regw_n = 0, irw_n = 0, model_cnt = 0;
    logic        funct_seen = 1'b0, prev_wait = 1'b0, prev_write = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            cyc = 0; pcw_n = 0; regw_n = 0; irw_n = 0; model_cnt = 0;
            funct_seen = 1'b0; prev_wait = 1'b0;
        end else begin
            if (prev_wait)
                check("req_stable_while_waiting", 32'({mem_req, mem_write}), 32'({1'b1, prev_write}));
            prev_wait  = mem_req && !mem_ready;
            prev_write = mem_write;
            if (!idle_stall) cyc++;
            pcw_n  += 32'(pc_write);
            regw_n += 32'(reg_write);
            irw_n  += 32'(ir_write);
            if (alu_op == 2'b10) funct_seen = 1'b1;
            if (instr_retired) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", 32'(instr_retired), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", 32'(cyc), 32'(e.lat));
                    check("instret_at_retire", 32'(instret), 32'(model_cnt));
                    check("pc_write_count", 32'(pcw_n), 32'(e.pcw));
                    check("reg_write_count", 32'(regw_n), 32'(e.regw));
                    check("ir_write_count", 32'(irw_n), 32'd1);
                    check("funct_alu_op_seen", 32'(funct_seen), 32'(e.funct));
                    case (e.op)
                        T_LW:  check("lw_writeback", 32'({reg_write, result_src}), 32'({1'b1, 2'b01}));
                        T_SW:  check("sw_retire_access", 32'({mem_req, mem_write, adr_src, reg_write}), 32'(4'b1110));
                        T_BEQ: check("beq_sub_branch", 32'({alu_op, pc_write, reg_write}), 32'({2'b01, e.z, 1'b0}));
                        default: check("alu_writeback", 32'({reg_write, result_src}), 32'({1'b1, 2'b00}));
                    endcase
                    model_cnt = (model_cnt + 1) % (1 << W);
                end
                cyc = 0; pcw_n = 0; regw_n = 0; irw_n = 0;
                funct_seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic z, input int unsigned wf, input int unsigned wd);
        instr_t      t;
        exp_t        e;
        int unsigned base;
        logic        is_mem;
        is_mem = (op == T_LW) || (op == T_SW);
        case (op)
            T_BEQ:   base = 3;
            T_LW:    base = 5;
            default: base = 4;
        endcase
        e.op    = op;
        e.z     = z;
        e.lat   = base + wf + (is_mem ? wd : 0);
        e.pcw   = 1 + ((op == T_JAL) ? 1 : 0) + ((op == T_BEQ && z) ? 1 : 0);
        e.regw  = (op == T_SW || op == T_BEQ) ? 0 : 1;
        e.funct = (op == T_R) || (op == T_I);
        t.op = op;
        t.z  = z;
        waits.push_back(wf);
        if (is_mem) waits.push_back(wd);
        sb.push_back(e);
        prog.push_back(t);
        total_issued++;
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned k = 0;
        while (sb.size() > 0 && k < bound) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() > 0) check("drain_timeout_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
        #2;
    endtask

    function automatic int unsigned rand_wait();
        return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
    endfunction

    initial begin
        logic [6:0] ops [6];
        ops[0] = T_LW; ops[1] = T_SW; ops[2] = T_R;
        ops[3] = T_I;  ops[4] = T_BEQ; ops[5] = T_JAL;

        // Reset state: every output but state_dbg low, state_dbg = FETCH.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_outputs_zero", 32'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal_instr, instret}), 32'd0);
        check("reset_state_dbg", 32'(state_dbg), 32'd0);

        // lw aborted by reset while waiting in MEMREAD.
        issue(T_LW, 1'b0, 0, 20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("lw_waiting_data_access", 32'({mem_req, adr_src, mem_write}), 32'(3'b110));
        reset = 1'b0;
        #1;
        check("midreset_outputs_zero", 32'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, alu_op, result_src, instr_retired, illegal_instr, instret}), 32'd0);
        check("midreset_state_dbg", 32'(state_dbg), 32'd0);
        prog.delete();
        waits.delete();
        sb.delete();
        total_issued = 0;
        @(negedge clk);
        issue(T_I, 1'b0, 2, 0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #2;
        check("after_release_state_dbg", 32'(state_dbg), 32'd0);
        check("after_release_instret", 32'(instret), 32'd0);
        check("after_release_no_retire", 32'(instr_retired), 32'd0);
        drain(200);

        // Directed: add, lw with 3-cycle data stall, beq both ways, jal, sw.
        issue(T_R,   1'b0, 0, 0);
        issue(T_LW,  1'b0, 0, 3);
        issue(T_BEQ, 1'b1, 0, 0);
        issue(T_BEQ, 1'b0, 0, 0);
        issue(T_JAL, 1'b0, 0, 0);
        issue(T_SW,  1'b0, 1, 2);
        drain(500);

        // 16 back-to-back addi: counter wraps.
        for (int i = 0; i < 16; i++) issue(T_I, 1'b0, 0, 0);
        drain(1000);
        check("instret_after_wrap", 32'(instret), 32'(total_issued % (1 << W)));

        // Random mix with random memory stalls.
        for (int i = 0; i < 60; i++)
            issue(ops[$urandom_range(0, 5)], 1'(($urandom_range(0, 1))), rand_wait(), rand_wait());
        drain(5000);
        check("instret_after_random", 32'(instret), 32'(total_issued % (1 << W)));

        // Unsupported opcode: TRAP holds with illegal_instr set.
        begin
            instr_t t;
            t.op = T_ECALL;
            t.z  = 1'b0;
            waits.push_back(0);
            prog.push_back(t);
        end
        repeat (4) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #2;
            check("trap_hold", 32'({illegal_instr, mem_req, instr_retired, pc_write, reg_write, ir_write}), 32'(6'b100000));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
